game_sequencer: RTL and testbench

Central whack-a-mole game controller. It sequences a round through four states: idle, pre-game countdown, timed play and post-game hold. It gates the mole handler's active clock via mole_enable_o, and accumulates a mode-weighted score from whack pulses. It drives the value and blanking that the SSD display path (B2BCD / SSDControl) consumes.

---
 rtl/game_pkg.sv | 20 ++
 rtl/sat_score_counter.sv | 45 ++++
 rtl/game_sequencer.sv | 125 ++++++++++++
 tb/tb_game_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the whack-a-mole game controller: FSM states, difficulty
// modes and score sizing.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_PLAYING   = 2'b10,
        ST_DONE      = 2'b11
    } state_t;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_SLOW   = 2'b01;
    localparam logic [1:0] MODE_MEDIUM = 2'b10;
    localparam logic [1:0] MODE_FAST   = 2'b11;

    localparam int SCORE_W           = 14;
    localparam int SCORE_MAX_DEFAULT = 9999;

endpackage

// File: rtl/sat_score_counter.sv
// Saturating score accumulator. The next value is exposed so the caller can
// register it into its own display register in the same cycle the score moves.
import game_pkg::*;

module sat_score_counter #(
    parameter int SCORE_MAX = SCORE_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               add,
    input  logic [1:0]         weight,
    output logic [SCORE_W-1:0] score_next
);

    logic [SCORE_W-1:0] score;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                   input logic [1:0] w);
        logic [SCORE_W:0] sum;
        sum = {1'b0, base} + {{(SCORE_W - 1){1'b0}}, w};
        if (sum > (SCORE_W + 1)'(SCORE_MAX)) begin
            return SCORE_W'(SCORE_MAX);
        end
        return sum[SCORE_W-1:0];
    endfunction

    always_comb begin
        score_next = score;
        if (clear) begin
            score_next = '0;
        end else if (add) begin
            score_next = sat_add(score, weight);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score <= '0;
        end else begin
            score <= score_next;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Whack-a-mole round controller: idle -> countdown -> timed play -> done, with a
// mode-weighted saturating score and registered SSD display value/blanking.
import game_pkg::*;

module game_sequencer #(
    parameter int COUNTDOWN_SECS = 3,
    parameter int GAME_SECS      = 30,
    parameter int SCORE_MAX      = SCORE_MAX_DEFAULT
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        tick_1hz_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [1:0]  mode_i,
    input  logic        whacked_i,
    output logic [1:0]  state_o,
    output logic [1:0]  mode_o,
    output logic        mole_enable_o,
    output logic [6:0]  time_left_o,
    output logic [13:0] display_value_o,
    output logic        display_blank_o,
    output logic        game_over_o
);

    state_t             state, state_next;
    logic [1:0]         mode_next;
    logic [3:0]         count, count_next;
    logic [6:0]         time_next;
    logic               clear, add;
    logic [SCORE_W-1:0] score_next;
    logic [13:0]        display_next;

    sat_score_counter #(
        .SCORE_MAX (SCORE_MAX)
    ) u_score (
        .clk        (clock_i),
        .rst        (reset_i),
        .clear      (clear),
        .add        (add),
        .weight     (mode_o),
        .score_next (score_next)
    );

    always_comb begin
        state_next = state;
        mode_next  = mode_o;
        count_next = count;
        time_next  = time_left_o;
        clear      = 1'b0;
        add        = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i && mode_i != MODE_NONE) begin
                    state_next = ST_COUNTDOWN;
                    mode_next  = mode_i;
                    count_next = 4'(COUNTDOWN_SECS);
                    clear      = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick_1hz_i) begin
                    if (count == 4'd1) begin
                        state_next = ST_PLAYING;
                        time_next  = 7'(GAME_SECS);
                        count_next = '0;
                    end else begin
                        count_next = count - 4'd1;
                    end
                end
            end
            ST_PLAYING: begin
                // A whack on the final tick still counts; both take effect together.
                add = whacked_i;
                if (tick_1hz_i) begin
                    if (time_left_o == 7'd1) begin
                        state_next = ST_DONE;
                        time_next  = '0;
                    end else begin
                        time_next = time_left_o - 7'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort_i && state != ST_IDLE) begin
            state_next = ST_IDLE;
            mode_next  = MODE_NONE;
            count_next = '0;
            time_next  = '0;
            clear      = 1'b1;
            add        = 1'b0;
        end
        case (state_next)
            ST_IDLE:      display_next = '0;
            ST_COUNTDOWN: display_next = {10'd0, count_next};
            default:      display_next = score_next;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state           <= ST_IDLE;
            mode_o          <= MODE_NONE;
            count           <= '0;
            time_left_o     <= '0;
            mole_enable_o   <= 1'b0;
            display_value_o <= '0;
            display_blank_o <= 1'b1;
            game_over_o     <= 1'b0;
        end else begin
            state           <= state_next;
            mode_o          <= mode_next;
            count           <= count_next;
            time_left_o     <= time_next;
            mole_enable_o   <= (state_next == ST_PLAYING);
            display_value_o <= display_next;
            display_blank_o <= (state_next == ST_IDLE);
            game_over_o     <= (state_next == ST_DONE) && (state != ST_DONE);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized and directed bench for game_sequencer against a rule-level game model.
module tb_game_sequencer;

    localparam int CD  = 3;
    localparam int GS  = 30;
    localparam int MAX = 9999;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        tick_1hz_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic        whacked_i = 1'b0;
    logic [1:0]  state_o;
    logic [1:0]  mode_o;
    logic        mole_enable_o;
    logic [6:0]  time_left_o;
    logic [13:0] display_value_o;
    logic        display_blank_o;
    logic        game_over_o;

    int checks = 0;
    int errors = 0;

    // Reference game: phase 0 idle, 1 countdown, 2 playing, 3 done.
    int m_phase = 0, m_mode = 0, m_score = 0, m_count = 0, m_time = 0;
    bit m_over = 0;

    game_sequencer #(.COUNTDOWN_SECS(CD), .GAME_SECS(GS), .SCORE_MAX(MAX)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .tick_1hz_i      (tick_1hz_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .mode_i          (mode_i),
        .whacked_i       (whacked_i),
        .state_o         (state_o),
        .mode_o          (mode_o),
        .mole_enable_o   (mole_enable_o),
        .time_left_o     (time_left_o),
        .display_value_o (display_value_o),
        .display_blank_o (display_blank_o),
        .game_over_o     (game_over_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [27:0] act_vec();
        return {state_o, mode_o, mole_enable_o, time_left_o, display_value_o,
                display_blank_o, game_over_o};
    endfunction

    function automatic logic [27:0] exp_vec();
        int shown;
        shown = (m_phase == 0) ? 0 : (m_phase == 1) ? m_count : m_score;
        return {2'(m_phase), 2'(m_mode), m_phase == 2, 7'(m_time), 14'(shown),
                m_phase == 0, m_over};
    endfunction

    task automatic drive(input bit rst, input bit start, input bit abort, input bit tick,
                         input bit whack, input logic [1:0] md);
        int prev;
        reset_i = rst; start_i = start; abort_i = abort; tick_1hz_i = tick;
        whacked_i = whack; mode_i = md;
        @(posedge clock_i);
        prev = m_phase;
        if (rst || (abort && m_phase != 0)) begin
            m_phase = 0; m_mode = 0; m_score = 0; m_count = 0; m_time = 0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (start && md != 2'b00) begin
                m_phase = 1; m_mode = int'(md); m_count = CD; m_score = 0;
            end
        end else if (m_phase == 1) begin
            if (tick) begin
                if (m_count == 1) begin m_phase = 2; m_time = GS; m_count = 0; end
                else m_count = m_count - 1;
            end
        end else begin
            if (whack) m_score = (m_score + m_mode > MAX) ? MAX : m_score + m_mode;
            if (tick) begin
                if (m_time == 1) begin m_phase = 3; m_time = 0; end
                else m_time = m_time - 1;
            end
        end
        m_over = !rst && m_phase == 3 && prev != 3;
        #1;
        reset_i = 0; start_i = 0; abort_i = 0; tick_1hz_i = 0; whacked_i = 0;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic enter_play(input logic [1:0] md);
        drive(0, 0, 1, 0, 0, 2'b00);
        drive(0, 1, 0, 0, 0, md);
        for (int i = 0; i < CD; i++) drive(0, 0, 0, 1, 0, 2'b00);
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 1, 1, 2'b11);
        drive(1, 0, 0, 0, 0, 2'b00);
        checks++;
        if (act_vec() !== 28'h000_0002) begin
            errors++; $display("FAIL reset_values: got %h expected %h", act_vec(), 28'h0000002);
        end
        drive(0, 1, 0, 0, 0, 2'b00);
        checks++;
        if (state_o !== 2'b00 || display_blank_o !== 1'b1 || mole_enable_o !== 1'b0) begin
            errors++; $display("FAIL start_mode00_ignored: got state=%0d blank=%0d mole=%0d expected 0 1 0",
                               state_o, display_blank_o, mole_enable_o);
        end
    endtask

    task automatic test_countdown();
        drive(0, 1, 0, 0, 0, 2'b10);
        for (int i = 0; i < CD; i++) begin
            checks++;
            if (state_o !== 2'b01 || display_value_o !== 14'(CD - i) || display_blank_o !== 1'b0) begin
                errors++; $display("FAIL countdown_%0d: got state=%0d disp=%0d expected 1 %0d",
                                   i, state_o, display_value_o, CD - i);
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) drive(0, 0, 0, 0, 1, 2'b01);
            drive(0, 0, 0, 1, 0, 2'b00);
        end
        checks++;
        if (state_o !== 2'b10 || time_left_o !== 7'd30 || mole_enable_o !== 1'b1 || mode_o !== 2'b10) begin
            errors++; $display("FAIL enter_playing: got st=%0d t=%0d mole=%0d mode=%0d expected 2 30 1 2",
                               state_o, time_left_o, mole_enable_o, mode_o);
        end
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL countdown_model: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_scoring();
        enter_play(2'b11);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 2'b00);
        checks++;
        if (display_value_o !== 14'd15) begin
            errors++; $display("FAIL five_fast_whacks: got %0d expected 15", display_value_o);
        end
    endtask

    task automatic test_saturation();
        enter_play(2'b10);
        for (int i = 0; i < 4999; i++) drive(0, 0, 0, 0, 1, 2'b00);
        checks++;
        if (display_value_o !== 14'd9998) begin
            errors++; $display("FAIL score_9998: got %0d expected 9998", display_value_o);
        end
        drive(0, 0, 0, 0, 1, 2'b00);
        checks++;
        if (display_value_o !== 14'd9999) begin
            errors++; $display("FAIL saturate_hit: got %0d expected 9999", display_value_o);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 2'b00);
        checks++;
        if (display_value_o !== 14'd9999 || act_vec() !== exp_vec()) begin
            errors++; $display("FAIL saturate_hold: got %0d expected 9999", display_value_o);
        end
    endtask

    task automatic test_final_tick_whack();
        enter_play(2'b01);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 2'b00);
        for (int i = 0; i < GS - 1; i++) drive(0, 0, 0, 1, 0, 2'b00);
        checks++;
        if (time_left_o !== 7'd1) begin
            errors++; $display("FAIL time_left_one: got %0d expected 1", time_left_o);
        end
        drive(0, 0, 0, 1, 1, 2'b00);
        checks++;
        if (state_o !== 2'b11 || game_over_o !== 1'b1 || display_value_o !== 14'd5 ||
            mole_enable_o !== 1'b0 || time_left_o !== 7'd0) begin
            errors++; $display("FAIL final_tick_whack: got st=%0d go=%0d disp=%0d mole=%0d expected 3 1 5 0",
                               state_o, game_over_o, display_value_o, mole_enable_o);
        end
        drive(0, 0, 0, 1, 1, 2'b00);
        checks++;
        if (game_over_o !== 1'b0 || display_value_o !== 14'd5 || state_o !== 2'b11) begin
            errors++; $display("FAIL done_hold: got go=%0d disp=%0d st=%0d expected 0 5 3",
                               game_over_o, display_value_o, state_o);
        end
    endtask

    task automatic test_restart_from_done();
        drive(0, 1, 0, 0, 0, 2'b01);
        checks++;
        if (state_o !== 2'b01 || mode_o !== 2'b01 || display_value_o !== 14'd3) begin
            errors++; $display("FAIL restart_countdown: got st=%0d mode=%0d disp=%0d expected 1 1 3",
                               state_o, mode_o, display_value_o);
        end
        for (int i = 0; i < CD; i++) drive(0, 0, 0, 1, 0, 2'b00);
        checks++;
        if (state_o !== 2'b10 || display_value_o !== 14'd0) begin
            errors++; $display("FAIL restart_score_cleared: got st=%0d disp=%0d expected 2 0",
                               state_o, display_value_o);
        end
    endtask

    task automatic test_abort_with_tick();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 2'b00);
        drive(0, 1, 1, 1, 1, 2'b11);
        checks++;
        if (state_o !== 2'b00 || display_value_o !== 14'd0 || display_blank_o !== 1'b1 ||
            mode_o !== 2'b00 || time_left_o !== 7'd0 || mole_enable_o !== 1'b0) begin
            errors++; $display("FAIL abort_with_tick: got %h expected %h", act_vec(), 28'h0000002);
        end
    endtask

    task automatic test_reset_mid_countdown();
        drive(0, 1, 0, 0, 0, 2'b11);
        drive(0, 0, 0, 1, 0, 2'b00);
        drive(1, 0, 0, 1, 0, 2'b00);
        checks++;
        if (act_vec() !== 28'h000_0002) begin
            errors++; $display("FAIL reset_mid_countdown: got %h expected %h", act_vec(), 28'h0000002);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 0), 2'($urandom_range(0, 3)));
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_scoring();
        test_saturation();
        test_final_tick_whack();
        test_restart_from_done();
        test_abort_with_tick();
        test_reset_mid_countdown();
        idle_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
